// File: rtl/divfreq_bank.sv
// Bank of three independent 50%-duty clock dividers with per-channel toggle strobes.
// Each channel counts CLK edges and flips its output every HALF edges.

module divfreq_ch #(
  parameter int HALF = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic div_o,
  output logic tick_o
);
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  if (HALF < 1) begin : g_bad_half
    $error("divfreq_ch: HALF must be >= 1 (got %0d)", HALF);
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_q, div_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    div_d  = div_q;
    tick_d = 1'b0;
    // The terminal-count compare is the only way back to zero.
    if (cnt_q == TERM) begin
      cnt_d  = '0;
      div_d  = ~div_q;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign div_o  = div_q;
  assign tick_o = tick_q;
endmodule

module divfreq_bank #(
  parameter int HALF1 = 12_500_000,
  parameter int HALF2 = 25_000_000,
  parameter int HALF3 = 2_500
) (
  input  logic CLK,
  input  logic Clear,
  output logic CLK_div,
  output logic CLK_div2,
  output logic CLK_div3,
  output logic tick1,
  output logic tick2,
  output logic tick3
);
  localparam int NUM_CH = 3;
  localparam int HALVES [NUM_CH] = '{HALF1, HALF2, HALF3};

  logic [NUM_CH-1:0] div, tick;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    divfreq_ch #(.HALF(HALVES[g])) u_ch (
      .clk_i  (CLK),
      .rst_i  (Clear),
      .div_o  (div[g]),
      .tick_o (tick[g])
    );
  end

  assign CLK_div  = div[0];
  assign CLK_div2 = div[1];
  assign CLK_div3 = div[2];
  assign tick1    = tick[0];
  assign tick2    = tick[1];
  assign tick3    = tick[2];
endmodule

// File: tb/tb_divfreq_bank.sv
// Bench for divfreq_bank: random Clear pulses and run lengths against an
// edge-count model, plus direct period/duty measurement of each output.
`timescale 1ns/100ps

module tb_divfreq_bank;
  localparam int H1 = 3, H2 = 5, H3 = 1;

  logic CLK = 1'b0;
  logic Clear = 1'b1;
  logic CLK_div, CLK_div2, CLK_div3, tick1, tick2, tick3;

  divfreq_bank #(.HALF1(H1), .HALF2(H2), .HALF3(H3)) dut (
    .CLK(CLK), .Clear(Clear),
    .CLK_div(CLK_div), .CLK_div2(CLK_div2), .CLK_div3(CLK_div3),
    .tick1(tick1), .tick2(tick2), .tick3(tick3)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int e = 0;                       // CLK edges counted since Clear released
  int halves [3] = '{H1, H2, H3};
  int last_rise [3] = '{-1, -1, -1};
  logic [2:0] prev_div = 3'b000;

  task automatic chk(input string tag, input int n, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s ch%0d edge%0d: observed %b expected %b", tag, n + 1, e, obs, want);
    end
  endtask

  task automatic chk_int(input string tag, input int n, input int obs, input int want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s ch%0d edge%0d: observed %0d expected %0d", tag, n + 1, e, obs, want);
    end
  endtask

  // Model: output is high during odd-numbered half periods; tick marks each toggle edge.
  function automatic logic want_div(int n);
    return ((e / halves[n]) % 2) == 1;
  endfunction

  function automatic logic want_tick(int n);
    return (e > 0) && (e % halves[n] == 0);
  endfunction

  task automatic check_all(input string tag);
    logic [2:0] d, t;
    d = {CLK_div3, CLK_div2, CLK_div};
    t = {tick3, tick2, tick1};
    for (int n = 0; n < 3; n++) begin
      chk({tag, "_div"}, n, d[n], want_div(n));
      chk({tag, "_tick"}, n, t[n], want_tick(n));
    end
  endtask

  task automatic measure();
    logic [2:0] d;
    d = {CLK_div3, CLK_div2, CLK_div};
    for (int n = 0; n < 3; n++) begin
      if (d[n] && !prev_div[n]) begin
        if (last_rise[n] >= 0) chk_int("period", n, e - last_rise[n], 2 * halves[n]);
        last_rise[n] = e;
      end else if (!d[n] && prev_div[n]) begin
        chk_int("high_time", n, e - last_rise[n], halves[n]);
      end
    end
    prev_div = d;
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    #1;
    if (!Clear) e++;
    check_all(tag);
    if (!Clear) measure();
  endtask

  // Assert Clear at a random point mid-cycle, hold for `hold` edges, release mid-cycle.
  task automatic do_clear(input int hold);
    @(posedge CLK);
    #($urandom_range(2, 8));
    Clear = 1'b1;
    #0.5;
    e = 0;
    check_all("clr_now");
    repeat (hold) step("clr_hold");
    @(posedge CLK);
    #($urandom_range(2, 8));
    Clear = 1'b0;
    last_rise = '{-1, -1, -1};
    prev_div  = 3'b000;
  endtask

  initial begin
    #2;
    check_all("reset");
    repeat (2) step("reset_hold");
    @(negedge CLK);
    Clear = 1'b0;

    repeat (12) step("run12");

    do_clear(1);
    repeat (4) step("pre_mid");
    do_clear(2);
    repeat (3) step("post_mid");

    for (int i = 0; i < 10; i++) begin
      do_clear($urandom_range(0, 3));
      repeat ($urandom_range(1, 40)) step("rand");
    end

    do_clear(1);
    repeat (1000) step("long");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end
endmodule
